// File: rtl/ex_fwd_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding/hazard unit:
// forwarding mux encodings and the per-stage register-usage slot.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Slot register fields are sized for the widest supported REG_W and
    // zero-extended on entry, so equality compares stay exact.
    localparam int unsigned SLOT_REG_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_REG_W-1:0] rs;
        logic [SLOT_REG_W-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic [SLOT_REG_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } pipe_slot_t;

    localparam pipe_slot_t EMPTY_SLOT = '{
        valid:    1'b0,
        rs:       {SLOT_REG_W{1'b0}},
        rt:       {SLOT_REG_W{1'b0}},
        use_rs:   1'b0,
        use_rt:   1'b0,
        rd:       {SLOT_REG_W{1'b0}},
        regwrite: 1'b0,
        memread:  1'b0
    };

    // True when the slot holds a live write to a non-zero register equal to r.
    function automatic logic slot_writes(input pipe_slot_t s,
                                         input logic [SLOT_REG_W-1:0] r);
        return s.valid & s.regwrite & (s.rd != {SLOT_REG_W{1'b0}}) & (s.rd == r);
    endfunction

endpackage

// File: rtl/ex_fwd_hazard_unit_fwd_sel_cmp.sv
// Per-operand forwarding select: compares one EX source register against the
// MEM and WB slots and returns the ALU operand mux select.
module fwd_sel_cmp
    import mips_pipe_pkg::*;
(
    input  logic                  ex_valid,
    input  logic [SLOT_REG_W-1:0] src,
    input  logic                  use_src,
    input  pipe_slot_t            mem_slot,
    input  pipe_slot_t            wb_slot,
    output logic [1:0]            sel
);

    logic mem_hit_s;
    logic wb_hit_s;
    logic unused_slot_bits_s;

    // A load still in MEM has no data yet, so it never forwards from MEM.
    assign mem_hit_s = slot_writes(mem_slot, src) & ~mem_slot.memread;
    assign wb_hit_s  = slot_writes(wb_slot, src);

    assign unused_slot_bits_s = ^{mem_slot.rs, mem_slot.rt, mem_slot.use_rs,
                                  mem_slot.use_rt, wb_slot.rs, wb_slot.rt,
                                  wb_slot.use_rs, wb_slot.use_rt, wb_slot.memread};

    // Priority select: youngest producer (MEM) first, then WB, else register file.
    always_comb begin
        sel = FWD_RF;
        if (!(ex_valid & use_src)) begin
            sel = FWD_RF;
        end else if (mem_hit_s) begin
            sel = FWD_MEM;
        end else if (wb_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/ex_fwd_hazard_unit.sv
// EX forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module ex_fwd_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic [REG_W-1:0] i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_memread,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic             o_stall,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_fwd_cnt
`endif
);

    if (REG_W > SLOT_REG_W || CNT_W == 0) begin : g_cfg_out_of_range
    end

    pipe_slot_t            ex_r;
    pipe_slot_t            mem_r;
    pipe_slot_t            wb_r;
    pipe_slot_t            id_slot_s;
    logic [SLOT_REG_W-1:0] id_rs_s;
    logic [SLOT_REG_W-1:0] id_rt_s;
    logic [SLOT_REG_W-1:0] id_rd_s;
    logic                  load_use_s;
    logic [1:0]            fwd_a_s;
    logic [1:0]            fwd_b_s;

    assign id_rs_s = SLOT_REG_W'(i_id_rs);
    assign id_rt_s = SLOT_REG_W'(i_id_rt);
    assign id_rd_s = SLOT_REG_W'(i_id_rd);

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_r.valid & ex_r.memread & i_id_valid) begin
            load_use_s = (i_id_use_rs & slot_writes(ex_r, id_rs_s)) |
                         (i_id_use_rt & slot_writes(ex_r, id_rt_s));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A flushed instruction needs no stall, and a held pipeline is already frozen.
    assign o_stall = load_use_s & ~i_flush & ~i_hold;

    // Build the next EX slot; flushes and load-use stalls become bubbles.
    always_comb begin
        id_slot_s          = EMPTY_SLOT;
        id_slot_s.valid    = i_id_valid & ~i_flush & ~load_use_s;
        id_slot_s.rs       = id_rs_s;
        id_slot_s.rt       = id_rt_s;
        id_slot_s.use_rs   = i_id_use_rs;
        id_slot_s.use_rt   = i_id_use_rt;
        id_slot_s.rd       = id_rd_s;
        id_slot_s.regwrite = i_id_regwrite;
        id_slot_s.memread  = i_id_memread;
    end

    // Shadow pipeline: advance EX->MEM->WB unless the whole core is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_r  <= EMPTY_SLOT;
            mem_r <= EMPTY_SLOT;
            wb_r  <= EMPTY_SLOT;
        end else if (!i_hold) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= id_slot_s;
        end
    end

    fwd_sel_cmp u_fwd_a (
        .ex_valid (ex_r.valid),
        .src      (ex_r.rs),
        .use_src  (ex_r.use_rs),
        .mem_slot (mem_r),
        .wb_slot  (wb_r),
        .sel      (fwd_a_s)
    );

    fwd_sel_cmp u_fwd_b (
        .ex_valid (ex_r.valid),
        .src      (ex_r.rt),
        .use_src  (ex_r.use_rt),
        .mem_slot (mem_r),
        .wb_slot  (wb_r),
        .sel      (fwd_b_s)
    );

    assign o_fwd_a = fwd_a_s;
    assign o_fwd_b = fwd_b_s;

`ifdef FWD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] fwd_cnt_r;
    logic             fwd_event_s;

    assign fwd_event_s = ~i_hold & ex_r.valid &
                         ((fwd_a_s != FWD_RF) | (fwd_b_s != FWD_RF));

    // Saturating event counters for stalls and forwarded operands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            fwd_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (o_stall && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (fwd_event_s && (fwd_cnt_r != CNT_MAX)) begin
                fwd_cnt_r <= fwd_cnt_r + CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_r;
    assign o_fwd_cnt   = fwd_cnt_r;
`endif

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
// Self-checking bench for ex_fwd_hazard_unit: directed vector table, a
// mid-run reset sequence, and random stimulus against an instruction-history model.
module tb_ex_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       hold;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef FWD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
`endif

    ex_fwd_hazard_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_use_rs   (id_use_rs),
        .i_id_use_rt   (id_use_rt),
        .i_id_rd       (id_rd),
        .i_id_regwrite (id_regwrite),
        .i_id_memread  (id_memread),
        .i_flush       (flush),
        .i_hold        (hold),
        .o_stall       (stall),
        .o_fwd_a       (fwd_a),
        .o_fwd_b       (fwd_b)
`ifdef FWD_STATS_EN
        ,
        .o_stall_cnt   (stall_cnt),
        .o_fwd_cnt     (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct packed {
        instr_t     ins;
        logic       fl;
        logic       ho;
        logic       st;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    vec_t   vecs[$];
    instr_t hist[$];  // [0]=EX, [1]=MEM, [2]=WB

    function automatic instr_t nop_i();
        return '0;
    endfunction

    function automatic instr_t alu_i(input int rd, input int rs, input int rt);
        instr_t x;
        x.v = 1'b1; x.rs = rs[4:0]; x.rt = rt[4:0]; x.urs = 1'b1; x.urt = 1'b1;
        x.rd = rd[4:0]; x.rw = 1'b1; x.mr = 1'b0;
        return x;
    endfunction

    function automatic instr_t ld_i(input int rd, input int rs);
        instr_t x;
        x.v = 1'b1; x.rs = rs[4:0]; x.rt = 5'd0; x.urs = 1'b1; x.urt = 1'b0;
        x.rd = rd[4:0]; x.rw = 1'b1; x.mr = 1'b1;
        return x;
    endfunction

    function automatic vec_t mkv(input instr_t i, input logic fl, input logic ho,
                                 input logic st, input logic [1:0] ea, input logic [1:0] eb);
        vec_t x;
        x.ins = i; x.fl = fl; x.ho = ho; x.st = st; x.ea = ea; x.eb = eb;
        return x;
    endfunction

    // Producer p delivers a usable write to register r.
    function automatic logic writes(input instr_t p, input logic [4:0] r);
        return p.v && p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    // Nearest older producer wins; a load one step ahead has no data yet.
    function automatic logic [1:0] model_sel(input logic [4:0] src, input logic use_it);
        if (!hist[0].v || !use_it) return 2'b00;
        for (int d = 1; d <= 2; d++) begin
            if (writes(hist[d], src) && !(d == 1 && hist[d].mr))
                return (d == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_load_use(input instr_t id);
        return id.v && hist[0].v && hist[0].mr &&
               ((id.urs && writes(hist[0], id.rs)) || (id.urt && writes(hist[0], id.rt)));
    endfunction

    task automatic drive(input instr_t i, input logic fl, input logic ho);
        id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs;
        id_use_rt = i.urt; id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr;
        flush = fl; hold = ho;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        instr_t r;
        instr_t e;
        logic   fl;
        logic   ho;
        logic   lu;

        // Directed table; each row shows the expected outputs while that ID is presented.
        vecs.push_back(mkv(alu_i(3, 1, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(4, 3, 5),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b10, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(7, 1, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(8, 7, 9),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b01, 2'b00));
        vecs.push_back(mkv(alu_i(3, 1, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(3, 4, 5),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(10, 3, 6), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b10, 2'b00));
        vecs.push_back(mkv(ld_i(2, 1),      1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b01, 2'b01));
        vecs.push_back(mkv(ld_i(2, 1),      1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(ld_i(2, 1),      1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b1, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(6, 2, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b01, 2'b01));
        vecs.push_back(mkv(alu_i(0, 1, 2),  1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(11, 0, 0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(ld_i(0, 1),      1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(alu_i(12, 0, 0), 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mkv(nop_i(),         1'b0, 1'b0, 1'b0, 2'b00, 2'b00));

        // Reset state
        rst_n = 1'b0;
        drive(nop_i(), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", {1'b0, stall}, 2'b00);
        check("reset fwd_a", fwd_a, 2'b00);
        check("reset fwd_b", fwd_b, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ins, vecs[i].fl, vecs[i].ho);
            @(negedge clk);
            check($sformatf("vec%0d stall", i), {1'b0, stall}, {1'b0, vecs[i].st});
            check($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].ea);
            check($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].eb);
            @(posedge clk);
            #1;
        end

        // Mid-run reset with a live stall and a MEM forward pending
        drive(alu_i(3, 1, 2), 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(ld_i(4, 3), 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(alu_i(6, 4, 4), 1'b0, 1'b0);
        @(negedge clk);
        check("prerst stall", {1'b0, stall}, 2'b01);
        check("prerst fwd_a", fwd_a, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        check("midrst stall", {1'b0, stall}, 2'b00);
        check("midrst fwd_a", fwd_a, 2'b00);
        check("midrst fwd_b", fwd_b, 2'b00);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        drive(alu_i(7, 3, 4), 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(nop_i(), 1'b0, 1'b0);
        @(negedge clk);
        check("postrst stall", {1'b0, stall}, 2'b00);
        check("postrst fwd_a", fwd_a, 2'b00);
        check("postrst fwd_b", fwd_b, 2'b00);

        // Random stimulus against the history model
        rst_n = 1'b0;
        drive(nop_i(), 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        hist = {nop_i(), nop_i(), nop_i()};
        for (int n = 0; n < 2000; n++) begin
            r.v   = ($urandom_range(0, 9) != 0);
            r.rs  = 5'($urandom_range(0, 3));
            r.rt  = 5'($urandom_range(0, 3));
            r.urs = 1'($urandom_range(0, 1));
            r.urt = 1'($urandom_range(0, 1));
            r.rd  = 5'($urandom_range(0, 3));
            r.rw  = ($urandom_range(0, 4) != 0);
            r.mr  = ($urandom_range(0, 2) == 0);
            fl    = ($urandom_range(0, 9) == 0);
            ho    = ($urandom_range(0, 9) == 0);
            drive(r, fl, ho);
            lu = model_load_use(r);
            @(negedge clk);
            check($sformatf("rnd%0d stall", n), {1'b0, stall}, {1'b0, lu && !fl && !ho});
            check($sformatf("rnd%0d fwd_a", n), fwd_a, model_sel(hist[0].rs, hist[0].urs));
            check($sformatf("rnd%0d fwd_b", n), fwd_b, model_sel(hist[0].rt, hist[0].urt));
            @(posedge clk);
            if (!ho) begin
                e   = r;
                e.v = r.v && !fl && !lu;
                hist.push_front(e);
                void'(hist.pop_back());
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
